// File: rtl/synth_pkg.sv
// Shared types for the additive-synthesis datapath: partial word layout and scanner states.
package synth_pkg;

   localparam int unsigned DEFAULT_PHASE_W = 24;

   typedef struct packed {
      logic [DEFAULT_PHASE_W-1:0] inc;
      logic [DEFAULT_PHASE_W-1:0] phase;
   } partial_word_t;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      SCAN
   } scan_state_t;

endpackage

// File: rtl/dist_ram.sv
// Distributed RAM: combinational read, synchronous write, no reset on contents.
module dist_ram #(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 64
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [WIDTH-1:0]         i_din,
   output logic [WIDTH-1:0]         o_dout
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_din;
      end
   end

   assign o_dout = r_mem[i_addr];

endmodule

// File: rtl/partial_phase_scanner.sv
// Sweeps all partials once per sample tick: reads {inc, phase}, writes back phase+inc and
// streams the pre-increment phase downstream. Also owns host config writes and post-reset clear.
module partial_phase_scanner
   import synth_pkg::*;
#(
   parameter int unsigned PHASE_W = DEFAULT_PHASE_W,
   parameter int unsigned DEPTH   = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sample_tick,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [$clog2(DEPTH)-1:0] cfg_addr,
   input  logic [PHASE_W-1:0]       cfg_inc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PHASE_W-1:0]       out_phase,
   output logic [$clog2(DEPTH)-1:0] out_index,
   output logic                     out_last,
   output logic                     busy,
   output logic                     overrun,
   output logic [$clog2(DEPTH)-1:0] ram_addr,
   output logic                     ram_we,
   output logic [2*PHASE_W-1:0]     ram_din,
   input  logic [2*PHASE_W-1:0]     ram_dout
);

   localparam int unsigned    AW       = $clog2(DEPTH);
   localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);

   scan_state_t        r_state, w_state_nxt;
   logic [AW-1:0]      r_idx, w_idx_nxt;
   logic               r_out_valid;
   logic [PHASE_W-1:0] r_out_phase;
   logic [AW-1:0]      r_out_index;
   logic               r_out_last;
   logic               r_overrun;

   logic               w_adv;
   logic               w_load;
   logic [PHASE_W-1:0] w_inc;
   logic [PHASE_W-1:0] w_phase;

   assign w_inc   = ram_dout[2*PHASE_W-1:PHASE_W];
   assign w_phase = ram_dout[PHASE_W-1:0];
   // Advance only when the output slot is free or being drained, so a stall never re-increments.
   assign w_adv   = !r_out_valid || out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      cfg_ready   = 1'b0;
      ram_addr    = r_idx;
      ram_we      = 1'b0;
      ram_din     = '0;
      unique case (r_state)
         CLEAR: begin
            ram_we    = 1'b1;
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
               w_idx_nxt   = '0;
               w_state_nxt = IDLE;
            end
         end
         IDLE: begin
            cfg_ready = !sample_tick;
            ram_addr  = cfg_addr;
            if (sample_tick) begin
               w_idx_nxt   = '0;
               w_state_nxt = SCAN;
            end else if (cfg_valid) begin
               ram_we  = 1'b1;
               ram_din = {cfg_inc, {PHASE_W{1'b0}}};
            end
         end
         SCAN: begin
            if (w_adv) begin
               ram_we    = 1'b1;
               ram_din   = {w_inc, w_phase + w_inc};
               w_load    = 1'b1;
               w_idx_nxt = r_idx + 1'b1;
               if (r_idx == LAST_IDX) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = CLEAR;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CLEAR;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_phase <= '0;
         r_out_index <= '0;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_phase <= w_phase;
         r_out_index <= r_idx;
         r_out_last  <= (r_idx == LAST_IDX);
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Ticks arriving mid-sweep are dropped; flag stays up until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (r_state == SCAN && sample_tick) begin
         r_overrun <= 1'b1;
      end
   end

   assign out_valid = r_out_valid;
   assign out_phase = r_out_phase;
   assign out_index = r_out_index;
   assign out_last  = r_out_last;
   assign overrun   = r_overrun;
   assign busy      = (r_state != IDLE) || r_out_valid;

endmodule
